dbg_addr_scanner: RTL and testbench

//   Debug-bus initiator: walks a window of debug addresses, issues one read
//   per address over a valid/ready request channel, collects each response,
//   and reports an XOR signature plus a non-zero-hit count. It is the

---
 rtl/dbg_scan_if.sv | 25 ++
 rtl/dbg_addr_scanner.sv | 181 ++++++++++++++++++
 tb/tb_dbg_addr_scanner.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dbg_scan_if.sv
// Request/response channel between the debug address scanner (master) and
// the debug address decoder (slave).
interface dbg_scan_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic [31:0] rsp_data;

    modport master (
        output req_valid,
        output req_addr,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        output req_ready,
        output rsp_valid,
        output rsp_data
    );
endinterface

// File: rtl/dbg_addr_scanner.sv
// Debug-bus scanner: reads NUM_ADDR addresses and reports an XOR signature and a non-zero hit count.
// Optional feature macro: DBG_SCAN_TIMEOUT_EN (per-address response timeout, sets sticky err_o).
module dbg_addr_scanner #(
    parameter logic [31:0] BASE_ADDR      = 32'd1,
    parameter logic [31:0] STRIDE         = 32'd1,
    parameter int unsigned NUM_ADDR       = 4,
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    dbg_scan_if.master  bus,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] signature_o,
    output logic [7:0]  hit_cnt_o,
    output logic        err_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_e;

    localparam logic [7:0] LAST_IDX = 8'(NUM_ADDR - 1);

    if ((NUM_ADDR < 1) || (NUM_ADDR > 255) || (TIMEOUT_CYCLES < 1)) begin : g_cfg_check
        $error("dbg_addr_scanner: NUM_ADDR must be 1..255 and TIMEOUT_CYCLES >= 1");
    end

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [7:0]  idx_q, idx_d;
    logic [31:0] sig_q, sig_d;
    logic [7:0]  hit_q, hit_d;
    logic        err_q, err_d;
    logic        req_valid_q, req_valid_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic start_take_s;
    logic rsp_take_s;
    logic timeout_s;
    logic advance_s;

    // A response is only accepted in WAIT, which starts the cycle after acceptance.
    assign start_take_s = (state_q == S_IDLE) && start_i;
    assign rsp_take_s   = (state_q == S_WAIT) && bus.rsp_valid;
    assign advance_s    = rsp_take_s || timeout_s;

`ifdef DBG_SCAN_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] to_cnt_q, to_cnt_d;

    assign timeout_s = (state_q == S_WAIT) && !bus.rsp_valid && (to_cnt_q == TO_LAST);

    // Counts silent WAIT cycles; cleared whenever the scanner is not waiting.
    always_comb begin
        to_cnt_d = 16'd0;
        if ((state_q == S_WAIT) && !bus.rsp_valid && (to_cnt_q != TO_LAST)) begin
            to_cnt_d = to_cnt_q + 16'd1;
        end else begin
            to_cnt_d = 16'd0;
        end
    end

    // Timeout counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt_q <= 16'd0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) state_d = S_REQ;
                else         state_d = S_IDLE;
            end
            S_REQ: begin
                if (bus.req_ready) state_d = S_WAIT;
                else               state_d = S_REQ;
            end
            S_WAIT: begin
                if (advance_s) begin
                    if (idx_q == LAST_IDX) state_d = S_DONE;
                    else                   state_d = S_REQ;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Scan datapath: address walk, signature, hit count and sticky error.
    always_comb begin
        addr_d = addr_q;
        idx_d  = idx_q;
        sig_d  = sig_q;
        hit_d  = hit_q;
        err_d  = err_q;
        if (start_take_s) begin
            addr_d = BASE_ADDR;
            idx_d  = 8'd0;
            sig_d  = 32'd0;
            hit_d  = 8'd0;
            err_d  = 1'b0;
        end else begin
            if (rsp_take_s) begin
                sig_d = sig_q ^ bus.rsp_data;
                if ((bus.rsp_data != 32'd0) && (hit_q != 8'hFF)) hit_d = hit_q + 8'd1;
                else                                              hit_d = hit_q;
            end else begin
                sig_d = sig_q;
                hit_d = hit_q;
            end
            if (timeout_s) err_d = 1'b1;
            else           err_d = err_q;
            // Address addition wraps modulo 2^32 by construction.
            if (advance_s && (idx_q != LAST_IDX)) begin
                addr_d = addr_q + STRIDE;
                idx_d  = idx_q + 8'd1;
            end else begin
                addr_d = addr_q;
                idx_d  = idx_q;
            end
        end
    end

    // Outputs are decoded from the next state so they can be registered.
    always_comb begin
        req_valid_d = (state_d == S_REQ);
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            addr_q      <= 32'd0;
            idx_q       <= 8'd0;
            sig_q       <= 32'd0;
            hit_q       <= 8'd0;
            err_q       <= 1'b0;
            req_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            idx_q       <= idx_d;
            sig_q       <= sig_d;
            hit_q       <= hit_d;
            err_q       <= err_d;
            req_valid_q <= req_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.req_valid = req_valid_q;
    assign bus.req_addr  = addr_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign signature_o   = sig_q;
    assign hit_cnt_o     = hit_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_dbg_addr_scanner.sv
// Directed bench for dbg_addr_scanner: a behavioural decoder answers reads,
// and each scan is checked against hand-computed addresses, signature and latency.
module tb_dbg_addr_scanner;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset       = 1'b1;
    logic start_cmd   = 1'b0;
    logic stray_start = 1'b0;
    logic sel_wrap    = 1'b0;
    logic start_s;
    assign start_s = start_cmd | stray_start;

    dbg_scan_if if_a ();
    dbg_scan_if if_b ();

    logic        busy_a, done_a, err_a, busy_b, done_b, err_b;
    logic [31:0] sig_a, sig_b;
    logic [7:0]  hit_a, hit_b;

    dbg_addr_scanner u_dut (
        .clk         (clk),
        .reset       (reset),
        .start_i     (start_s & ~sel_wrap),
        .bus         (if_a),
        .busy_o      (busy_a),
        .done_o      (done_a),
        .signature_o (sig_a),
        .hit_cnt_o   (hit_a),
        .err_o       (err_a)
    );

    dbg_addr_scanner #(.BASE_ADDR(32'hFFFF_FFFE)) u_dut_wrap (
        .clk         (clk),
        .reset       (reset),
        .start_i     (start_s & sel_wrap),
        .bus         (if_b),
        .busy_o      (busy_b),
        .done_o      (done_b),
        .signature_o (sig_b),
        .hit_cnt_o   (hit_b),
        .err_o       (err_b)
    );

    logic        obs_valid, obs_busy, obs_done, obs_err;
    logic [31:0] obs_addr, obs_sig;
    logic [7:0]  obs_hit;
    assign obs_valid = sel_wrap ? if_b.req_valid : if_a.req_valid;
    assign obs_addr  = sel_wrap ? if_b.req_addr  : if_a.req_addr;
    assign obs_busy  = sel_wrap ? busy_b : busy_a;
    assign obs_done  = sel_wrap ? done_b : done_a;
    assign obs_err   = sel_wrap ? err_b  : err_a;
    assign obs_sig   = sel_wrap ? sig_b  : sig_a;
    assign obs_hit   = sel_wrap ? hit_b  : hit_a;

    logic        dec_ready = 1'b0;
    logic        dec_rsp_valid = 1'b0;
    logic [31:0] dec_rsp_data = 32'd0;
    assign if_a.req_ready = dec_ready;
    assign if_b.req_ready = dec_ready;
    assign if_a.rsp_valid = dec_rsp_valid;
    assign if_b.rsp_valid = dec_rsp_valid;
    assign if_a.rsp_data  = dec_rsp_data;
    assign if_b.rsp_data  = dec_rsp_data;

    int          n_vec = 0;
    int          n_err = 0;
    int          stall_cfg = 0;
    logic        drop_en = 1'b0;
    logic [31:0] drop_addr = 32'd0;
    logic        stray_en = 1'b0;
    logic        chk_stable = 1'b0;
    logic [31:0] exp_base = 32'd1;
    int          stall_left = 0;
    logic        acc_pend = 1'b0;
    logic [31:0] acc_addr = 32'd0;
    logic [31:0] addr_log[$];

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] dec_model(input logic [31:0] a);
        if (a == 32'd1)      return 32'd1;
        else if (a == 32'd2) return 32'd2;
        else                 return 32'd0;
    endfunction

    // Behavioural decoder: drives ready/response on the falling edge.
    always @(negedge clk) begin
        dec_rsp_valid = 1'b0;
        dec_rsp_data  = 32'd0;
        if (acc_pend) begin
            acc_pend = 1'b0;
            if (!(drop_en && (acc_addr == drop_addr))) begin
                dec_rsp_valid = 1'b1;
                dec_rsp_data  = dec_model(acc_addr);
            end
        end
        if (obs_valid) begin
            if (chk_stable)
                check_val("stall_addr", obs_addr, exp_base + 32'(addr_log.size()));
            if (stall_left > 0) begin
                dec_ready  = 1'b0;
                stall_left = stall_left - 1;
            end else begin
                dec_ready = 1'b1;
                acc_pend  = 1'b1;
                acc_addr  = obs_addr;
                addr_log.push_back(obs_addr);
            end
            if (stray_en) begin
                dec_rsp_valid = 1'b1;
                dec_rsp_data  = 32'h0000_00F0;
            end
        end else begin
            dec_ready  = 1'b0;
            stall_left = stall_cfg;
            if (stray_en && !obs_busy) begin
                dec_rsp_valid = 1'b1;
                dec_rsp_data  = 32'h0000_00F0;
            end
        end
        stray_start = stray_en && obs_valid;
    end

    task automatic run_scan(input int max_cyc, output int lat, output logic saw_done);
        @(negedge clk);
        start_cmd = 1'b1;
        @(posedge clk);
        #1 start_cmd = 1'b0;
        lat = 0;
        saw_done = 1'b0;
        while (!saw_done && (lat < max_cyc)) begin
            @(negedge clk);
            lat++;
            if (obs_done) saw_done = 1'b1;
        end
    endtask

    task automatic check_addrs(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                               input logic [31:0] e2, input logic [31:0] e3);
        logic [31:0] exp_a[4];
        exp_a[0] = e0; exp_a[1] = e1; exp_a[2] = e2; exp_a[3] = e3;
        check_val({tag, "_n"}, 32'(addr_log.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < addr_log.size()) check_val($sformatf("%s_a%0d", tag, i), addr_log[i], exp_a[i]);
        end
    endtask

    initial begin
        int   lat;
        logic saw;
        int   found;
        int   dones;
        logic [31:0] exp_idle_sig;
        logic [7:0]  exp_idle_hit;

        repeat (3) @(negedge clk);
        check_val("rst_busy", 32'(obs_busy), 32'd0);
        check_val("rst_done", 32'(obs_done), 32'd0);
        check_val("rst_valid", 32'(obs_valid), 32'd0);
        check_val("rst_addr", obs_addr, 32'd0);
        check_val("rst_sig", obs_sig, 32'd0);
        check_val("rst_hit", 32'(obs_hit), 32'd0);
        check_val("rst_err", 32'(obs_err), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Test 1: zero-wait scan
        addr_log.delete();
        run_scan(40, lat, saw);
        check_val("t1_done", 32'(saw), 32'd1);
        check_val("t1_lat", 32'(lat), 32'd9);
        check_val("t1_busy", 32'(obs_busy), 32'd1);
        check_val("t1_sig", obs_sig, 32'd3);
        check_val("t1_hit", 32'(obs_hit), 32'd2);
        check_val("t1_err", 32'(obs_err), 32'd0);
        check_addrs("t1", 32'd1, 32'd2, 32'd3, 32'd4);
        @(negedge clk);
        check_val("t1_done_pulse", 32'(obs_done), 32'd0);
        check_val("t1_idle", 32'(obs_busy), 32'd0);
        repeat (3) @(negedge clk);
        check_val("t1_sig_hold", obs_sig, 32'd3);
        check_val("t1_hit_hold", 32'(obs_hit), 32'd2);

        // Test 2: three stall cycles in every REQ
        stall_cfg = 3;
        exp_base = 32'd1;
        repeat (2) @(negedge clk);
        addr_log.delete();
        chk_stable = 1'b1;
        run_scan(60, lat, saw);
        chk_stable = 1'b0;
        check_val("t2_done", 32'(saw), 32'd1);
        check_val("t2_lat", 32'(lat), 32'd21);
        check_val("t2_sig", obs_sig, 32'd3);
        check_val("t2_hit", 32'(obs_hit), 32'd2);
        check_addrs("t2", 32'd1, 32'd2, 32'd3, 32'd4);
        stall_cfg = 0;
        repeat (2) @(negedge clk);

        // Test 3: address wrap on the second instance
        sel_wrap = 1'b1;
        repeat (2) @(negedge clk);
        addr_log.delete();
        run_scan(40, lat, saw);
        check_val("t3_done", 32'(saw), 32'd1);
        check_val("t3_lat", 32'(lat), 32'd9);
        check_addrs("t3", 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0, 32'd1);
        check_val("t3_sig", obs_sig, 32'd1);
        check_val("t3_hit", 32'(obs_hit), 32'd1);
        @(negedge clk);
        sel_wrap = 1'b0;
        repeat (2) @(negedge clk);

        // Test 4: reset during WAIT of the second address
        @(negedge clk);
        start_cmd = 1'b1;
        @(posedge clk);
        #1 start_cmd = 1'b0;
        found = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (obs_busy && !obs_valid && (obs_addr == 32'd2)) begin
                found = 1;
                break;
            end
        end
        check_val("t4_reach_wait", 32'(found), 32'd1);
        check_val("t4_pre_sig", obs_sig, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check_val("t4_busy", 32'(obs_busy), 32'd0);
        check_val("t4_valid", 32'(obs_valid), 32'd0);
        check_val("t4_done", 32'(obs_done), 32'd0);
        check_val("t4_addr", obs_addr, 32'd0);
        check_val("t4_sig", obs_sig, 32'd0);
        check_val("t4_hit", 32'(obs_hit), 32'd0);
        reset = 1'b0;
        dones = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (obs_done) dones++;
        end
        check_val("t4_no_done", 32'(dones), 32'd0);
        addr_log.delete();
        run_scan(40, lat, saw);
        check_val("t4_rescan_lat", 32'(lat), 32'd9);
        check_val("t4_rescan_sig", obs_sig, 32'd3);
        check_addrs("t4", 32'd1, 32'd2, 32'd3, 32'd4);
        repeat (2) @(negedge clk);

        // Test 5: no response for address 3
        drop_en = 1'b1;
        drop_addr = 32'd3;
        addr_log.delete();
`ifdef DBG_SCAN_TIMEOUT_EN
        run_scan(60, lat, saw);
        check_val("t5_done", 32'(saw), 32'd1);
        check_val("t5_lat", 32'(lat), 32'd23);
        check_val("t5_err", 32'(obs_err), 32'd1);
        check_val("t5_sig", obs_sig, 32'd3);
        check_val("t5_hit", 32'(obs_hit), 32'd2);
        check_addrs("t5", 32'd1, 32'd2, 32'd3, 32'd4);
        exp_idle_sig = 32'd3;
        exp_idle_hit = 8'd2;
`else
        run_scan(40, lat, saw);
        check_val("t5_no_done", 32'(saw), 32'd0);
        check_val("t5_busy", 32'(obs_busy), 32'd1);
        check_val("t5_valid", 32'(obs_valid), 32'd0);
        check_val("t5_addr", obs_addr, 32'd3);
        check_val("t5_err", 32'(obs_err), 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_idle_sig = 32'd0;
        exp_idle_hit = 8'd0;
`endif
        drop_en = 1'b0;
        repeat (2) @(negedge clk);

        // Test 6: stray start pulses and stray responses
        stray_en = 1'b1;
        repeat (5) @(negedge clk);
        check_val("t6_idle_sig", obs_sig, exp_idle_sig);
        check_val("t6_idle_hit", 32'(obs_hit), 32'(exp_idle_hit));
        check_val("t6_idle_busy", 32'(obs_busy), 32'd0);
        addr_log.delete();
        run_scan(40, lat, saw);
        check_val("t6_lat", 32'(lat), 32'd9);
        check_val("t6_sig", obs_sig, 32'd3);
        check_val("t6_hit", 32'(obs_hit), 32'd2);
        check_addrs("t6", 32'd1, 32'd2, 32'd3, 32'd4);
        repeat (4) @(negedge clk);
        check_val("t6_post_busy", 32'(obs_busy), 32'd0);
        check_val("t6_post_sig", obs_sig, 32'd3);
        check_val("t6_post_hit", 32'(obs_hit), 32'd2);
        stray_en = 1'b0;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
